stage_sequencer: RTL and testbench
==================================

# stage_sequencer

Parametrised multicycle stage sequencer for the RISC-V core, generalising the fixed five-stage counter. It steps the shared datapath through NUM_STAGES stages and emits a one-cycle start strobe on entry to each stage. It adds flush/restart, halt and single-step debug control, a retire pulse, and a retired-instruction counter. It sits between the control unit, which drives blocked/flush, and the debug block, which drives halt_req/step.

## Interface

- NUM_STAGES, default 5: stages per instruction, indexed 0 (fetch) to NUM_STAGES-1; must be ≥ 2.
- STAGE_W, default 3: width of the stage code; must satisfy 2^STAGE_W ≥ NUM_STAGES+1.
- RETIRE_W, default 32: width of the retired-instruction counter.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- blocked  in  1  hold the current stage (memory/bus wait).
- flush  in  1  abort the current instruction and restart at stage 0.
- halt_req  in  1  level; park at the next instruction boundary while high.
- step  in  1  while halted, run exactly one instruction, then re-halt.
- stage  out  STAGE_W  current stage index; all-ones = IDLE (reset or halted).
- stage_start  out  NUM_STAGES  one-hot strobe; bit k is high only in the first cycle of stage k.
- halted  out  1  high while parked in HALTED.
- retire  out  1  one-cycle pulse after the last stage completes.
- instret  out  RETIRE_W  retired-instruction count.

## Operation

- **States:** RESET_IDLE, RUN(k) for k = 0..NUM_STAGES-1, and HALTED. There is also an internal step_armed flag.
- **Priority per edge:** rst > flush > blocked > normal advance.
- **rst = 1:**
  - stage = all-ones, stage_start = 0, halted = 0, retire = 0.
  - instret = 0, step_armed = 0.
- **RESET_IDLE:**
  - If !blocked or flush: go to HALTED when halt_req = 1, otherwise go to RUN(0).
  - Otherwise hold.
- **RUN(k), k < NUM_STAGES-1:**
  - flush: go to RUN(0).
  - !blocked: go to RUN(k+1).
  - blocked: hold.
- **RUN(NUM_STAGES-1):**
  - flush: go to RUN(0) with no retire.
  - !blocked: the instruction completes; retire pulses and instret increments. The next state is HALTED if halt_req or step_armed, otherwise RUN(0). step_armed is cleared.
  - blocked: hold.
- **HALTED:**
  - halted = 1 and stage = all-ones. flush is ignored.
  - If !blocked and step = 1: go to RUN(0) and set step_armed.
  - Else if !blocked and halt_req = 0: go to RUN(0) (resume).
  - Otherwise hold.
- **Entering RUN(k):** always registers stage_start[k] = 1 for exactly one cycle, including re-entry of RUN(0) by flush from RUN(0).
- **Holds:** remaining in a stage never re-pulses stage_start.
- **Flush during a stepped instruction:** restarts at RUN(0) and keeps step_armed.
- **Counter:** instret wraps modulo 2^RETIRE_W with no saturation.

## Timing

- All outputs are registered; there is no combinational input-to-output path.
- stage_start[k] is asserted in the same cycle that stage first reads k.
- retire is asserted in the first cycle after the completing edge, i.e. the same cycle as stage_start[0] or the first halted cycle. instret shows the incremented value in that same cycle.
- With blocked = 0, an instruction occupies exactly NUM_STAGES cycles. Back-to-back instructions have no bubble.
- The first stage_start[0] appears one cycle after rst deasserts (given blocked = 0).
- halt_req is sampled only at the completing edge of RUN(NUM_STAGES-1), at the RESET_IDLE exit edge, and while in HALTED. A pulse between these sample points is lost.
- Halt-to-run latency is one cycle: HALTED → RUN(0) on the edge where step = 1 or halt_req = 0.

## Test plan

- **Free run.** Release rst, blocked = 0, NUM_STAGES = 5.
  - stage goes all-ones → 0,1,2,3,4,0…
  - stage_start walks 00001…10000; retire pulses every 5th cycle, coincident with stage_start[0].
  - instret = 3 after 15 run cycles.
- **Blocking.** Hold blocked = 1 for 4 cycles in stage 2.
  - stage stays 2 for 5 cycles; stage_start[2] pulses once; no retire change.
  - The instruction takes 9 cycles.
- **Flush.** Assert flush in stage 3, with blocked = 1 in the same cycle.
  - Next cycle: stage = 0, stage_start[0] = 1, retire = 0, instret unchanged.
  - Flush in stage 0 re-pulses stage_start[0].
- **Halt and step.** Assert halt_req mid-instruction.
  - The instruction finishes, retire pulses, and halted = 1 with stage all-ones.
  - Step pulse → exactly 5 RUN cycles, then halted again with instret + 1.
  - Dropping halt_req → resume next cycle.
- **Halt-on-reset.** Hold halt_req = 1 through rst release.
  - The block goes straight to HALTED with no stage_start and instret = 0.
  - Flush while halted is ignored.
- **Wrap and mid-run reset.** RETIRE_W = 4.
  - 17 instructions → instret = 1.
  - Assert rst in stage 3: next cycle all outputs are at their reset values and step_armed is cleared.

Source files
------------

// File: rtl/stage_sequencer.sv
// Purpose : steps the shared datapath through NUM_STAGES stages per instruction, with flush,
//           halt/single-step debug control, a retire pulse and a wrapping retired-instruction count.
// Latency : all outputs registered; stage k and stage_start[k] appear one cycle after the advancing edge.
// Backpressure: blocked holds the current stage (flush still wins); halt parks at instruction boundaries.
// Ports   : clk, rst (sync, active-high); blocked, flush from control; halt_req, step from debug;
//           stage (all-ones = idle/halted), stage_start (one-hot entry strobe), halted, retire, instret.
module stage_sequencer #(
  parameter int NUM_STAGES = 5,
  parameter int STAGE_W    = 3,
  parameter int RETIRE_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  blocked,
  input  logic                  flush,
  input  logic                  halt_req,
  input  logic                  step,
  output logic [STAGE_W-1:0]    stage,
  output logic [NUM_STAGES-1:0] stage_start,
  output logic                  halted,
  output logic                  retire,
  output logic [RETIRE_W-1:0]   instret
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALTED
  } state_t;

  localparam logic [STAGE_W-1:0] LAST_K = STAGE_W'(NUM_STAGES - 1);

  state_t             state_q, state_d;
  logic [STAGE_W-1:0] k_q, k_d;
  logic               step_armed_q, step_armed_d;
  logic               enter;      // entering RUN(k_d) on this edge
  logic               retire_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      step_armed_q <= 1'b0;
      stage        <= '1;
      stage_start  <= '0;
      halted       <= 1'b0;
      retire       <= 1'b0;
      instret      <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      step_armed_q <= step_armed_d;
      // Outputs are computed from the next state so they line up with it in the following cycle.
      stage        <= (state_d == S_RUN) ? k_d : '1;
      stage_start  <= enter ? (NUM_STAGES'(1) << k_d) : '0;
      halted       <= (state_d == S_HALTED);
      retire       <= retire_d;
      if (retire_d) begin
        instret <= instret + RETIRE_W'(1);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    step_armed_d = step_armed_q;
    enter        = 1'b0;
    retire_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!blocked || flush) begin
          if (halt_req) begin
            state_d = S_HALTED;
          end else begin
            state_d = S_RUN;
            k_d     = '0;
            enter   = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (flush) begin
          // Restart the instruction; step_armed survives so a stepped instruction still re-halts.
          k_d   = '0;
          enter = 1'b1;
        end else if (!blocked) begin
          if (k_q != LAST_K) begin
            k_d   = k_q + STAGE_W'(1);
            enter = 1'b1;
          end else begin
            retire_d     = 1'b1;
            step_armed_d = 1'b0;
            k_d          = '0;
            if (halt_req || step_armed_q) begin
              state_d = S_HALTED;
            end else begin
              enter = 1'b1;
            end
          end
        end
      end

      S_HALTED: begin
        // flush is deliberately ignored here: there is no instruction in flight to abort.
        if (!blocked && (step || !halt_req)) begin
          state_d = S_RUN;
          k_d     = '0;
          enter   = 1'b1;
          if (step) begin
            step_armed_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Purpose : directed self-checking bench for stage_sequencer (NUM_STAGES=5, RETIRE_W=4).
// Latency : inputs change 1ns after a rising edge; outputs are checked at that same point.
// Backpressure: blocked/flush/halt/step are driven from hand-written vectors.
module tb_stage_sequencer;

  localparam int NS = 5;
  localparam int SW = 3;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          blocked;
  logic          flush;
  logic          halt_req;
  logic          step;
  logic [SW-1:0] stage;
  logic [NS-1:0] stage_start;
  logic          halted;
  logic          retire;
  logic [RW-1:0] instret;

  int total = 0;
  int bad   = 0;

  stage_sequencer #(.NUM_STAGES(NS), .STAGE_W(SW), .RETIRE_W(RW)) dut (
    .clk        (clk),
    .rst        (rst),
    .blocked    (blocked),
    .flush      (flush),
    .halt_req   (halt_req),
    .step       (step),
    .stage      (stage),
    .stage_start(stage_start),
    .halted     (halted),
    .retire     (retire),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int stg, input int ss, input int hl,
                            input int rt, input int ir);
    chk({tag, ".stage"},       32'(stage),       32'(stg));
    chk({tag, ".stage_start"}, 32'(stage_start), 32'(ss));
    chk({tag, ".halted"},      32'(halted),      32'(hl));
    chk({tag, ".retire"},      32'(retire),      32'(rt));
    chk({tag, ".instret"},     32'(instret),     32'(ir));
  endtask

  initial begin
    rst = 1'b1; blocked = 1'b0; flush = 1'b0; halt_req = 1'b0; step = 1'b0;
    tick();
    expect_out("reset", 7, 0, 0, 0, 0);

    // Free run: 0,1,2,3,4,0,... retire with every stage_start[0] after the first.
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      expect_out($sformatf("run%0d", i), i % NS, 1 << (i % NS), 0,
                 (i % NS == 0 && i > 0) ? 1 : 0, i / NS);
    end
    // now stage 0, instret 3

    // Blocking for 4 cycles in stage 2.
    tick(); expect_out("blk_s1", 1, 5'b00010, 0, 0, 3);
    tick(); expect_out("blk_s2", 2, 5'b00100, 0, 0, 3);
    blocked = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); expect_out($sformatf("blk_hold%0d", i), 2, 0, 0, 0, 3);
    end
    blocked = 1'b0;
    tick(); expect_out("blk_s3", 3, 5'b01000, 0, 0, 3);
    tick(); expect_out("blk_s4", 4, 5'b10000, 0, 0, 3);
    tick(); expect_out("blk_ret", 0, 5'b00001, 0, 1, 4);

    // Flush in stage 3 with blocked also high, then flush in stage 0.
    tick(); tick(); tick();
    expect_out("fl_s3", 3, 5'b01000, 0, 0, 4);
    flush = 1'b1; blocked = 1'b1;
    tick(); expect_out("fl_from3", 0, 5'b00001, 0, 0, 4);
    blocked = 1'b0;
    tick(); expect_out("fl_from0", 0, 5'b00001, 0, 0, 4);
    flush = 1'b0;
    tick(); expect_out("fl_s1", 1, 5'b00010, 0, 0, 4);

    // Halt mid-instruction: finishes, retires, parks.
    halt_req = 1'b1;
    tick(); tick(); tick();
    expect_out("h_s4", 4, 5'b10000, 0, 0, 4);
    tick(); expect_out("h_park", 7, 0, 1, 1, 5);
    tick(); expect_out("h_stay", 7, 0, 1, 0, 5);

    // Single step with halt_req held: 5 run cycles then re-halt.
    step = 1'b1;
    tick(); expect_out("st_s0", 0, 5'b00001, 0, 0, 5);
    step = 1'b0;
    for (int i = 1; i < NS; i++) begin
      tick(); expect_out($sformatf("st_s%0d", i), i, 1 << i, 0, 0, 5);
    end
    tick(); expect_out("st_rehalt", 7, 0, 1, 1, 6);

    // Step, drop halt_req, flush mid-instruction: step_armed alone must re-halt.
    step = 1'b1;
    tick(); expect_out("sa_s0", 0, 5'b00001, 0, 0, 6);
    step = 1'b0; halt_req = 1'b0;
    tick(); expect_out("sa_s1", 1, 5'b00010, 0, 0, 6);
    flush = 1'b1;
    tick(); expect_out("sa_flush", 0, 5'b00001, 0, 0, 6);
    flush = 1'b0;
    tick(); tick(); tick(); tick();
    expect_out("sa_s4", 4, 5'b10000, 0, 0, 6);
    tick(); expect_out("sa_rehalt", 7, 0, 1, 1, 7);

    // Resume on halt_req low (already low): one-cycle halt-to-run.
    tick(); expect_out("resume", 0, 5'b00001, 0, 0, 7);

    // Halt-on-reset and ignored flush while halted.
    rst = 1'b1; halt_req = 1'b1;
    tick(); expect_out("hr_reset", 7, 0, 0, 0, 0);
    rst = 1'b0;
    tick(); expect_out("hr_park", 7, 0, 1, 0, 0);
    flush = 1'b1;
    tick(); expect_out("hr_flush_ign", 7, 0, 1, 0, 0);
    flush = 1'b0;

    // Wrap: 17 instructions with a 4-bit counter leave instret = 1.
    halt_req = 1'b0;
    tick(); expect_out("wr_start", 0, 5'b00001, 0, 0, 0);
    for (int i = 0; i < 17 * NS; i++) tick();
    expect_out("wr_17", 0, 5'b00001, 0, 1, 1);

    // Arm a step, then reset mid-instruction: step_armed must be cleared.
    halt_req = 1'b1;
    for (int i = 0; i < NS; i++) tick();
    expect_out("mr_park", 7, 0, 1, 1, 2);
    step = 1'b1;
    tick(); expect_out("mr_step", 0, 5'b00001, 0, 0, 2);
    step = 1'b0; halt_req = 1'b0;
    tick(); tick(); tick();
    expect_out("mr_s3", 3, 5'b01000, 0, 0, 2);
    rst = 1'b1;
    tick(); expect_out("mr_reset", 7, 0, 0, 0, 0);
    rst = 1'b0;
    tick(); expect_out("mr_run0", 0, 5'b00001, 0, 0, 0);
    for (int i = 0; i < NS; i++) tick();
    expect_out("mr_noarm", 0, 5'b00001, 0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
